// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states,
// byte-enable patterns and the latency counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam int LAT_W = 3;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: enables and replicated store data from size/offset, load
// extraction with sign/zero extension. Purely combinational, no flow control.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    be         = BE_NONE;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    rdata_ext  = shifted;
    case (size)
      SZ_BYTE: begin
        be        = BE_BYTE0 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        be         = offset[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misaligned = |offset;
        be         = BE_WORD;
      end
      default: misaligned = 1'b1;
    endcase
    // Rejected accesses must never present a live lane to memory.
    if (misaligned) be = BE_NONE;
  end

endmodule

// File: rtl/dmem_master.sv
// Data-memory initiator: one load/store in flight, response 1 (error), 2 (store)
// or 2+MEM_LATENCY (load) cycles after accept; ready only in IDLE/RESP.
module dmem_master
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        Mem_Read_o,
  output logic        Mem_Write_o,
  input  logic [31:0] mem_rdata_i
);

  localparam bit LAT_ZERO = (MEM_LATENCY == 0);
  localparam int unsigned LAT_LAST_I = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_LAST_I);

  state_t           state;
  logic             cap_write;
  logic             cap_unsigned;
  logic [1:0]       cap_size;
  logic [1:0]       cap_offset;
  logic [LAT_W-1:0] wait_cnt;
  logic             accept;

  logic [1:0]  al_size;
  logic [1:0]  al_offset;
  logic        al_unsigned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misaligned;

  assign req_ready_o = (state == ST_IDLE) || (state == ST_RESP);
  assign accept      = req_valid_i && req_ready_o;

  // Accept (IDLE/RESP) and read capture (ISSUE/WAIT) never share a cycle, so one
  // aligner serves both: live request fields while ready, captured ones otherwise.
  assign al_size     = req_ready_o ? req_size_i       : cap_size;
  assign al_offset   = req_ready_o ? req_addr_i[1:0]  : cap_offset;
  assign al_unsigned = req_ready_o ? req_unsigned_i   : cap_unsigned;

  dmem_lane_align u_align (
    .size        (al_size),
    .offset      (al_offset),
    .is_unsigned (al_unsigned),
    .wdata       (req_wdata_i),
    .rdata       (mem_rdata_i),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .rdata_ext   (al_rdata),
    .misaligned  (al_misaligned)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      cap_write    <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= SZ_BYTE;
      cap_offset   <= 2'b00;
      wait_cnt     <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= BE_NONE;
      Mem_Read_o   <= 1'b0;
      Mem_Write_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      Mem_Read_o   <= 1'b0;
      Mem_Write_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            cap_write    <= req_write_i;
            cap_unsigned <= req_unsigned_i;
            cap_size     <= req_size_i;
            cap_offset   <= req_addr_i[1:0];
            mem_addr_o   <= {req_addr_i[31:2], 2'b00};
            mem_be_o     <= al_be;
            mem_wdata_o  <= al_wdata;
            if (al_misaligned) begin
              state        <= ST_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
            end else begin
              state       <= ST_ISSUE;
              Mem_Write_o <= req_write_i;
              Mem_Read_o  <= !req_write_i;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (cap_write || LAT_ZERO) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            if (!cap_write) resp_rdata_o <= al_rdata;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAT_LAST) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            resp_rdata_o <= al_rdata;
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench: dut0 (combinational memory) and dut3 (3-cycle memory) with
// hand-computed expectations for accesses, errors, back-to-back and reset abort.
module tb_dmem_master;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // dut0: MEM_LATENCY = 0
  logic        v0, w0, u0, rdy0, rv0, re0, mr0, mw0;
  logic [1:0]  s0;
  logic [31:0] a0, wd0, rd0, ma0, mwd0, mrd0;
  logic [3:0]  be0;
  // dut3: MEM_LATENCY = 3
  logic        v3, w3, u3, rdy3, rv3, re3, mr3, mw3;
  logic [1:0]  s3;
  logic [31:0] a3, wd3, rd3, ma3, mwd3, mrd3;
  logic [3:0]  be3;

  dmem_master #(.MEM_LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(v0), .req_ready_o(rdy0),
    .req_write_i(w0), .req_size_i(s0), .req_unsigned_i(u0), .req_addr_i(a0),
    .req_wdata_i(wd0), .resp_valid_o(rv0), .resp_err_o(re0), .resp_rdata_o(rd0),
    .mem_addr_o(ma0), .mem_wdata_o(mwd0), .mem_be_o(be0), .Mem_Read_o(mr0),
    .Mem_Write_o(mw0), .mem_rdata_i(mrd0)
  );

  dmem_master #(.MEM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(v3), .req_ready_o(rdy3),
    .req_write_i(w3), .req_size_i(s3), .req_unsigned_i(u3), .req_addr_i(a3),
    .req_wdata_i(wd3), .resp_valid_o(rv3), .resp_err_o(re3), .resp_rdata_o(rd3),
    .mem_addr_o(ma3), .mem_wdata_o(mwd3), .mem_be_o(be3), .Mem_Read_o(mr3),
    .Mem_Write_o(mw3), .mem_rdata_i(mrd3)
  );

  // Byte-lane memory for dut0, 16 words, preloaded with the test pattern at 0x20.
  logic [31:0] mem0 [16];
  assign mrd0 = mem0[ma0[5:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem0[i] <= 32'h0;
      mem0[8] <= 32'h80FF7F01;
    end else if (mw0) begin
      for (int i = 0; i < 4; i++)
        if (be0[i]) mem0[ma0[5:2]][8*i +: 8] <= mwd0[8*i +: 8];
    end
  end

  // dut3 memory: data is only valid exactly 3 cycles after the read strobe cycle.
  logic [2:0] rd_pipe;
  always @(posedge clk) begin
    if (!rst_n) rd_pipe <= 3'b000;
    else        rd_pipe <= {rd_pipe[1:0], mr3};
  end
  assign mrd3 = rd_pipe[2] ? 32'h80FF7F01 : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    v0 = 1'b1; w0 = wr; s0 = sz; u0 = uns; a0 = addr; wd0 = wd;
  endtask

  task automatic req3(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    v3 = 1'b1; w3 = wr; s3 = sz; u3 = uns; a3 = addr; wd3 = wd;
  endtask

  task automatic load0(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] exp);
    check({tag, " ready"}, rdy0, 1);
    req0(1'b0, sz, uns, addr, 32'h0);
    tick();
    v0 = 1'b0;
    check({tag, " rd strobe"}, mr0, 1);
    tick();
    check({tag, " resp_valid"}, rv0, 1);
    check({tag, " rdata"}, rd0, exp);
    tick();
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    v0 = 0; w0 = 0; s0 = SZ_BYTE; u0 = 0; a0 = 0; wd0 = 0;
    v3 = 0; w3 = 0; s3 = SZ_BYTE; u3 = 0; a3 = 0; wd3 = 0;
    #2;
    check("rst ready0", rdy0, 1);
    check("rst resp_valid0", rv0, 0);
    check("rst resp_rdata0", rd0, 0);
    check("rst strobes0", {mr0, mw0}, 0);
    check("rst mem_addr0", ma0, 0);
    check("rst mem_be0", be0, 0);
    check("rst mem_wdata0", mwd0, 0);
    check("rst ready3", rdy3, 1);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Word store then load
    check("sw ready", rdy0, 1);
    req0(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    tick();
    v0 = 1'b0;
    check("sw wr strobe", mw0, 1);
    check("sw no rd strobe", mr0, 0);
    check("sw be", be0, 4'b1111);
    check("sw addr", ma0, 32'h10);
    check("sw wdata", mwd0, 32'hDEADBEEF);
    check("sw busy", rdy0, 0);
    check("sw no early resp", rv0, 0);
    tick();
    check("sw resp_valid", rv0, 1);
    check("sw resp_err", re0, 0);
    check("sw resp_rdata", rd0, 0);
    check("sw strobe one cycle", mw0, 0);
    tick();
    check("sw resp one cycle", rv0, 0);
    load0("lw 0x10", SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);

    // Sub-word loads from 0x80FF7F01
    load0("lb 0x23", SZ_BYTE, 1'b0, 32'h23, 32'hFFFFFF80);
    load0("lbu 0x23", SZ_BYTE, 1'b1, 32'h23, 32'h00000080);
    load0("lb 0x20", SZ_BYTE, 1'b0, 32'h20, 32'h00000001);
    load0("lb 0x21", SZ_BYTE, 1'b0, 32'h21, 32'h0000007F);
    load0("lh 0x22", SZ_HALF, 1'b0, 32'h22, 32'hFFFF80FF);
    load0("lhu 0x22", SZ_HALF, 1'b1, 32'h22, 32'h000080FF);

    // SB then SH accepted back-to-back in RESP
    req0(1'b1, SZ_BYTE, 1'b0, 32'h05, 32'h000000AB);
    tick();
    v0 = 1'b0;
    check("sb addr", ma0, 32'h04);
    check("sb be", be0, 4'b0010);
    check("sb wdata", mwd0, 32'hABABABAB);
    check("sb wr strobe", mw0, 1);
    tick();
    check("sb resp_valid", rv0, 1);
    check("sb ready in resp", rdy0, 1);
    req0(1'b1, SZ_HALF, 1'b0, 32'h06, 32'h00001234);
    tick();
    v0 = 1'b0;
    check("sh addr", ma0, 32'h04);
    check("sh be", be0, 4'b1100);
    check("sh wdata", mwd0, 32'h12341234);
    check("sh wr strobe", mw0, 1);
    tick();
    check("sh resp_valid", rv0, 1);
    tick();
    load0("lw 0x04", SZ_WORD, 1'b0, 32'h04, 32'h1234AB00);

    // Illegal accesses, chained so each error is accepted in the previous RESP
    req0(1'b0, SZ_HALF, 1'b0, 32'h01, 32'h0);
    tick();
    check("lh 0x01 resp_valid", rv0, 1);
    check("lh 0x01 err", re0, 1);
    check("lh 0x01 rdata", rd0, 0);
    check("lh 0x01 strobes", {mr0, mw0}, 0);
    check("lh 0x01 ready", rdy0, 1);
    req0(1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0);
    tick();
    check("lw 0x02 resp_valid", rv0, 1);
    check("lw 0x02 err", re0, 1);
    check("lw 0x02 rdata", rd0, 0);
    check("lw 0x02 strobes", {mr0, mw0}, 0);
    req0(1'b1, SZ_ILL, 1'b0, 32'h0, 32'hFFFFFFFF);
    tick();
    v0 = 1'b0;
    check("sz11 resp_valid", rv0, 1);
    check("sz11 err", re0, 1);
    check("sz11 rdata", rd0, 0);
    check("sz11 strobes", {mr0, mw0}, 0);
    tick();
    check("err idle resp_valid", rv0, 0);
    check("err idle ready", rdy0, 1);

    // MEM_LATENCY = 3 with a request held from T+1
    check("l3 ready", rdy3, 1);
    req3(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    tick();
    check("l3 rd strobe", mr3, 1);
    check("l3 no wr strobe", mw3, 0);
    check("l3 addr", ma3, 32'h20);
    check("l3 be", be3, 4'b1111);
    check("l3 wdata", mwd3, 32'h0);
    check("l3 busy issue", rdy3, 0);
    req3(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("l3 busy wait", rdy3, 0);
      check("l3 no early resp", rv3, 0);
      check("l3 strobe dropped", mr3, 0);
    end
    tick();
    check("l3 resp_valid", rv3, 1);
    check("l3 rdata", rd3, 32'h80FF7F01);
    check("l3 err", re3, 0);
    check("l3 ready in resp", rdy3, 1);
    tick();
    v3 = 1'b0;
    check("l3 held accepted", mr3, 1);
    check("l3 held resp off", rv3, 0);
    repeat (3) tick();
    check("l3 held no early resp", rv3, 0);
    tick();
    check("l3 held resp_valid", rv3, 1);
    check("l3 held rdata", rd3, 32'hFFFF80FF);
    tick();

    // Reset during ISSUE drops the strobe immediately
    req3(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0);
    tick();
    v3 = 1'b0;
    check("rst issue strobe before", mr3, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst issue strobe async", mr3, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Reset during WAIT aborts with no stale response
    req3(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0);
    tick();
    v3 = 1'b0;
    tick();
    check("rst wait busy", rdy3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst wait ready", rdy3, 1);
    check("rst wait strobes", {mr3, mw3}, 0);
    check("rst wait resp_valid", rv3, 0);
    check("rst wait rdata", rd3, 0);
    tick();
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | rv3 | mr3;
    end
    check("no stale resp", seen, 0);
    check("post rst ready", rdy3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
